// File: rtl/irq_encoder_148_pkg.sv
// irq_enc_defs: FSM state encodings and the board's default edge/level line map
package irq_enc_defs;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [7:0] EDGE_MASK_DEFAULT = 8'h00;
endpackage

// File: rtl/irq_encoder_148_sync_bus.sv
// sync_bus: ce-gated multi-bit synchronizer chain with configurable reset value
module sync_bus #(
    parameter int WIDTH = 8,
    parameter int STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] chain [STAGES];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= RESET_VAL;
        end else if (ce) begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end
    assign q = chain[STAGES-1];
endmodule

// File: rtl/irq_encoder_148.sv
// irq_encoder_148: clocked 74148-style priority encoder with CPU interrupt handshake
module irq_encoder_148 import irq_enc_defs::*; #(
    parameter int WIDTH_IN = 8,
    parameter int WIDTH_OUT = $clog2(WIDTH_IN),
    parameter logic [WIDTH_IN-1:0] EDGE_MASK = EDGE_MASK_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 Enable_bar,
    input  logic [WIDTH_IN-1:0]  Req_bar,
    input  logic                 Ack,
    output logic                 Irq,
    output logic [WIDTH_OUT-1:0] A_bar,
    output logic                 GS_bar,
    output logic                 EO_bar
);
    logic [WIDTH_IN-1:0] s, s_d, pending, pending_nx, clr;
    logic [WIDTH_OUT-1:0] enc_code, code_q;
    logic [1:0] state, state_nx;
    logic any;
    sync_bus #(.WIDTH(WIDTH_IN), .STAGES(SYNC_STAGES), .RESET_VAL('1)) u_sync (
        .clk(clk), .rst(rst), .ce(ce), .d(Req_bar), .q(s)
    );
    assign any = |pending;
    always_comb begin
        enc_code = '0;
        for (int i = 0; i < WIDTH_IN; i++)
            if (pending[i]) enc_code = WIDTH_OUT'(i);
    end
    // a new falling edge on the line being acknowledged must survive the clear
    assign clr = (state == ST_ASSERT && Ack) ? (EDGE_MASK & (WIDTH_IN'(1) << code_q)) : '0;
    assign pending_nx = (EDGE_MASK & ((pending & ~clr) | (s_d & ~s))) | (~EDGE_MASK & ~s);
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else if (ce) state <= state_nx;
    end
    always_comb begin
        state_nx = state == ST_IDLE    ? ((!Enable_bar && any) ? ST_ASSERT : ST_IDLE)
                 : state == ST_ASSERT  ? (Ack ? ST_RELEASE : Enable_bar ? ST_IDLE : ST_ASSERT)
                 : state == ST_RELEASE ? (Ack ? ST_RELEASE : ST_IDLE)
                 : ST_IDLE;
    end
    always_comb begin
        Irq   = state == ST_ASSERT;
        A_bar = Irq ? ~code_q : '1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s_d     <= '1;
            pending <= '0;
            code_q  <= '0;
            GS_bar  <= 1'b1;
            EO_bar  <= 1'b1;
        end else if (ce) begin
            s_d     <= s;
            pending <= pending_nx;
            if (state == ST_IDLE) code_q <= enc_code;
            GS_bar  <= Enable_bar | ~any;
            EO_bar  <= Enable_bar | any;
        end
    end
endmodule

// File: tb/tb_irq_encoder_148.sv
// tb_irq_encoder_148: scenario tasks plus an Irq-rise scoreboard on edge and level instances
module tb_irq_encoder_148;
    logic clk = 0, rst = 1, ce = 1, Enable_bar = 0, Ack = 0;
    logic [7:0] req_e = 8'hFF, req_l = 8'hFF;
    logic irq_e, irq_l, gs_e, gs_l, eo_e, eo_l;
    logic [2:0] a_e, a_l;
    logic irq_e_q = 0, irq_l_q = 0;
    logic [2:0] exp_e [$];
    logic [2:0] exp_l [$];
    int checks = 0, errors = 0;

    irq_encoder_148 #(.EDGE_MASK(8'hFF)) dut_e (
        .clk(clk), .rst(rst), .ce(ce), .Enable_bar(Enable_bar), .Req_bar(req_e), .Ack(Ack),
        .Irq(irq_e), .A_bar(a_e), .GS_bar(gs_e), .EO_bar(eo_e)
    );
    irq_encoder_148 #(.EDGE_MASK(8'h00)) dut_l (
        .clk(clk), .rst(rst), .ce(ce), .Enable_bar(Enable_bar), .Req_bar(req_l), .Ack(Ack),
        .Irq(irq_l), .A_bar(a_l), .GS_bar(gs_l), .EO_bar(eo_l)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // scoreboard: every Irq rise must present the next expected vector
    always @(negedge clk) begin
        if (!rst && irq_e && !irq_e_q) begin
            checks++;
            if (exp_e.size() == 0) begin
                errors++;
                $display("FAIL sb_edge: unexpected Irq rise A_bar=%b", a_e);
            end else begin
                logic [2:0] x;
                x = exp_e.pop_front();
                if (a_e !== x) begin
                    errors++;
                    $display("FAIL sb_edge: A_bar=%b expected %b", a_e, x);
                end
            end
        end
        if (!rst && irq_l && !irq_l_q) begin
            checks++;
            if (exp_l.size() == 0) begin
                errors++;
                $display("FAIL sb_level: unexpected Irq rise A_bar=%b", a_l);
            end else begin
                logic [2:0] x;
                x = exp_l.pop_front();
                if (a_l !== x) begin
                    errors++;
                    $display("FAIL sb_level: A_bar=%b expected %b", a_l, x);
                end
            end
        end
        irq_e_q = irq_e;
        irq_l_q = irq_l;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_ce(input int n);
        repeat (n) begin
            ce = 1;
            tick(1);
            ce = 0;
            tick(2);
        end
    endtask

    task automatic test_reset;
        rst = 1;
        req_e = 8'h00;
        req_l = 8'h00;
        tick(3);
        checks += 8;
        if (irq_e !== 1'b0) begin errors++; $display("FAIL reset_irq_e: got %b want 0", irq_e); end
        if (a_e !== 3'b111) begin errors++; $display("FAIL reset_a_e: got %b want 111", a_e); end
        if (gs_e !== 1'b1) begin errors++; $display("FAIL reset_gs_e: got %b want 1", gs_e); end
        if (eo_e !== 1'b1) begin errors++; $display("FAIL reset_eo_e: got %b want 1", eo_e); end
        if (irq_l !== 1'b0) begin errors++; $display("FAIL reset_irq_l: got %b want 0", irq_l); end
        if (a_l !== 3'b111) begin errors++; $display("FAIL reset_a_l: got %b want 111", a_l); end
        if (gs_l !== 1'b1) begin errors++; $display("FAIL reset_gs_l: got %b want 1", gs_l); end
        if (eo_l !== 1'b1) begin errors++; $display("FAIL reset_eo_l: got %b want 1", eo_l); end
        req_e = 8'hFF;
        req_l = 8'hFF;
        tick(1);
        rst = 0;
        tick(4);
    endtask

    task automatic test_edge;
        req_e = 8'hDF;
        exp_e.push_back(3'b010);
        tick(3);
        checks++;
        if (irq_e !== 1'b0) begin errors++; $display("FAIL edge_early: Irq=%b want 0 at 3 cycles", irq_e); end
        tick(1);
        checks += 3;
        if (irq_e !== 1'b1) begin errors++; $display("FAIL edge_latency: Irq=%b want 1 at 4 cycles", irq_e); end
        if (a_e !== 3'b010) begin errors++; $display("FAIL edge_code: A_bar=%b want 010", a_e); end
        if (gs_e !== 1'b0) begin errors++; $display("FAIL edge_gs: GS_bar=%b want 0", gs_e); end
        Ack = 1;
        tick(1);
        checks += 2;
        if (irq_e !== 1'b0) begin errors++; $display("FAIL edge_ack: Irq=%b want 0", irq_e); end
        if (a_e !== 3'b111) begin errors++; $display("FAIL edge_ack_a: A_bar=%b want 111", a_e); end
        Ack = 0;
        tick(6);
        checks++;
        if (irq_e !== 1'b0) begin errors++; $display("FAIL edge_no_reassert: Irq=%b want 0", irq_e); end
        req_e = 8'hFF;
        tick(4);
    endtask

    task automatic test_priority;
        req_e = 8'hBB;
        exp_e.push_back(3'b001);
        tick(4);
        checks++;
        if (a_e !== 3'b001) begin errors++; $display("FAIL prio_first: A_bar=%b want 001", a_e); end
        req_e = 8'h3B;
        exp_e.push_back(3'b000);
        exp_e.push_back(3'b101);
        tick(4);
        checks += 2;
        if (irq_e !== 1'b1) begin errors++; $display("FAIL prio_freeze_irq: Irq=%b want 1", irq_e); end
        if (a_e !== 3'b001) begin errors++; $display("FAIL prio_freeze: A_bar=%b want 001", a_e); end
        Ack = 1;
        tick(1);
        checks++;
        if (irq_e !== 1'b0) begin errors++; $display("FAIL prio_ack1: Irq=%b want 0", irq_e); end
        Ack = 0;
        tick(2);
        checks += 2;
        if (irq_e !== 1'b1) begin errors++; $display("FAIL prio_line7_irq: Irq=%b want 1", irq_e); end
        if (a_e !== 3'b000) begin errors++; $display("FAIL prio_line7: A_bar=%b want 000", a_e); end
        Ack = 1;
        tick(1);
        Ack = 0;
        tick(2);
        checks++;
        if (a_e !== 3'b101) begin errors++; $display("FAIL prio_line2: A_bar=%b want 101", a_e); end
        Ack = 1;
        tick(1);
        Ack = 0;
        tick(3);
        checks++;
        if (irq_e !== 1'b0) begin errors++; $display("FAIL prio_drained: Irq=%b want 0", irq_e); end
        req_e = 8'hFF;
        tick(4);
    endtask

    task automatic test_level;
        req_l = 8'hFE;
        exp_l.push_back(3'b111);
        tick(4);
        checks++;
        if (irq_l !== 1'b1) begin errors++; $display("FAIL level_raise: Irq=%b want 1", irq_l); end
        for (int k = 0; k < 2; k++) begin
            exp_l.push_back(3'b111);
            Ack = 1;
            tick(1);
            checks++;
            if (irq_l !== 1'b0) begin errors++; $display("FAIL level_ack%0d: Irq=%b want 0", k, irq_l); end
            Ack = 0;
            tick(2);
            checks++;
            if (irq_l !== 1'b1) begin errors++; $display("FAIL level_reraise%0d: Irq=%b want 1", k, irq_l); end
        end
        req_l = 8'hFF;
        tick(4);
        checks++;
        if (irq_l !== 1'b1) begin errors++; $display("FAIL level_stale: Irq=%b want 1", irq_l); end
        Ack = 1;
        tick(1);
        Ack = 0;
        tick(3);
        checks += 3;
        if (irq_l !== 1'b0) begin errors++; $display("FAIL level_idle: Irq=%b want 0", irq_l); end
        if (eo_l !== 1'b0) begin errors++; $display("FAIL level_eo: EO_bar=%b want 0", eo_l); end
        if (gs_l !== 1'b1) begin errors++; $display("FAIL level_gs: GS_bar=%b want 1", gs_l); end
    endtask

    task automatic test_withdraw;
        req_e = 8'hEF;
        exp_e.push_back(3'b011);
        exp_e.push_back(3'b011);
        tick(4);
        Enable_bar = 1;
        tick(1);
        checks += 4;
        if (irq_e !== 1'b0) begin errors++; $display("FAIL wd_irq: Irq=%b want 0", irq_e); end
        if (a_e !== 3'b111) begin errors++; $display("FAIL wd_a: A_bar=%b want 111", a_e); end
        if (gs_e !== 1'b1) begin errors++; $display("FAIL wd_gs: GS_bar=%b want 1", gs_e); end
        if (eo_e !== 1'b1) begin errors++; $display("FAIL wd_eo: EO_bar=%b want 1", eo_e); end
        Enable_bar = 0;
        tick(1);
        checks += 2;
        if (irq_e !== 1'b1) begin errors++; $display("FAIL wd_represent: Irq=%b want 1", irq_e); end
        if (a_e !== 3'b011) begin errors++; $display("FAIL wd_code: A_bar=%b want 011", a_e); end
        Ack = 1;
        tick(1);
        Ack = 0;
        req_e = 8'hFF;
        tick(4);
    endtask

    task automatic test_ce_gating;
        req_e = 8'hDF;
        exp_e.push_back(3'b010);
        tick_ce(3);
        checks++;
        if (irq_e !== 1'b0) begin errors++; $display("FAIL ce_early: Irq=%b want 0 at 3 ce", irq_e); end
        tick_ce(1);
        checks += 2;
        if (irq_e !== 1'b1) begin errors++; $display("FAIL ce_latency: Irq=%b want 1 at 4 ce", irq_e); end
        if (a_e !== 3'b010) begin errors++; $display("FAIL ce_code: A_bar=%b want 010", a_e); end
        req_e = 8'hFF;
        tick_ce(3);
        checks++;
        if (irq_e !== 1'b1) begin errors++; $display("FAIL ce_hold: Irq=%b want 1", irq_e); end
        // new falling edge lands on the same ce edge that accepts Ack
        req_e = 8'hDF;
        tick_ce(2);
        Ack = 1;
        exp_e.push_back(3'b010);
        tick_ce(1);
        checks++;
        if (irq_e !== 1'b0) begin errors++; $display("FAIL ce_ack: Irq=%b want 0", irq_e); end
        Ack = 0;
        tick_ce(2);
        checks += 2;
        if (irq_e !== 1'b1) begin errors++; $display("FAIL set_wins: Irq=%b want 1", irq_e); end
        if (a_e !== 3'b010) begin errors++; $display("FAIL set_wins_code: A_bar=%b want 010", a_e); end
        Ack = 1;
        tick_ce(1);
        Ack = 0;
        tick_ce(3);
        checks++;
        if (irq_e !== 1'b0) begin errors++; $display("FAIL ce_drained: Irq=%b want 0", irq_e); end
        ce = 1;
        req_e = 8'hFF;
        tick(4);
    endtask

    initial begin
        test_reset;
        test_edge;
        test_priority;
        test_level;
        test_withdraw;
        test_ce_gating;
        checks += 2;
        if (exp_e.size() != 0) begin errors++; $display("FAIL sb_edge_left: %0d pending want 0", exp_e.size()); end
        if (exp_l.size() != 0) begin errors++; $display("FAIL sb_level_left: %0d pending want 0", exp_l.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
